// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: latches one instruction word and steps it through
// FETCH/DECODE/EXEC/MEM/WB, driving datapath mux selects, strobes and memory handshakes.
module multicycle_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_instr,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic               i_mem_ready,
    input  logic               i_beq,
    input  logic               i_blt,
    output logic               o_pc_we,
    output logic               o_pc_sel,
    output logic               o_reg_we,
    output logic [2:0]         o_imm_sel,
    output logic               o_a_sel,
    output logic               o_b_sel,
    output logic               o_br_un,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [1:0]         o_wb_sel,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [2:0]         o_mem_size,
    output logic               o_illegal,
    output logic [2:0]         o_dbg_state,
    output logic [31:0]        o_dbg_ir
);

    // Handshake: an instruction transfers on a rising edge where i_instr_valid and
    // o_instr_ready are both high; o_instr_ready is high only in FETCH outside reset.

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_ADD   = 4'd4;
    localparam logic [3:0] ALU_SUB   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_illegal;

    logic [6:0]         w_opcode;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [4:0]         w_rd;
    logic               w_is_store;
    logic               w_is_load;
    logic               w_is_branch;
    logic               w_is_jump;
    logic               w_dec_ok;
    logic               w_taken;
    logic [3:0]         w_alu;
    logic               w_timeout;

    assign w_opcode    = r_ir[6:0];
    assign w_rd        = r_ir[11:7];
    assign w_f3        = r_ir[14:12];
    assign w_f7        = r_ir[31:25];
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_jump   = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);
    assign w_timeout   = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

    assign o_alu_op    = ALUOP_W'(w_alu);
    assign o_mem_size  = w_f3;
    assign o_illegal   = r_illegal;
    assign o_dbg_state = r_state;
    assign o_dbg_ir    = r_ir;

    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    f3_to_alu = alt ? ALU_SUB : ALU_ADD;
            3'd1:    f3_to_alu = ALU_SLL;
            3'd2:    f3_to_alu = ALU_SLT;
            3'd3:    f3_to_alu = ALU_SLTU;
            3'd4:    f3_to_alu = ALU_XOR;
            3'd5:    f3_to_alu = alt ? ALU_SRA : ALU_SRL;
            3'd6:    f3_to_alu = ALU_OR;
            default: f3_to_alu = ALU_AND;
        endcase
    endfunction

    // Legality of the latched word; branch funct3 2/3 is caught later in EXEC.
    always_comb begin
        w_dec_ok = 1'b1;
        case (w_opcode)
            OP_R:      w_dec_ok = (w_f7 == 7'h00) ||
                                  ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)));
            OP_IMM: begin
                if (w_f3 == 3'd1)
                    w_dec_ok = (w_f7 == 7'h00);
                else if (w_f3 == 3'd5)
                    w_dec_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);
            end
            OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_BRANCH: w_dec_ok = 1'b1;
            default:   w_dec_ok = 1'b0;
        endcase
    end

    // Datapath setup depends only on the IR, so it stays stable through EXEC/MEM/WB.
    always_comb begin
        w_alu     = ALU_ADD;
        o_imm_sel = 3'd0;
        o_a_sel   = 1'b0;
        o_b_sel   = 1'b1;
        o_br_un   = 1'b0;
        o_wb_sel  = 2'd1;
        case (w_opcode)
            OP_R: begin
                o_b_sel = 1'b0;
                w_alu   = f3_to_alu(w_f3, w_f7[5]);
            end
            OP_IMM:    w_alu = f3_to_alu(w_f3, (w_f3 == 3'd5) && w_f7[5]);
            OP_LOAD:   o_wb_sel = 2'd0;
            OP_STORE:  o_imm_sel = 3'd1;
            OP_LUI: begin
                o_imm_sel = 3'd3;
                w_alu     = ALU_PASSB;
            end
            OP_AUIPC: begin
                o_a_sel   = 1'b1;
                o_imm_sel = 3'd3;
            end
            OP_JAL: begin
                o_a_sel   = 1'b1;
                o_imm_sel = 3'd4;
                o_wb_sel  = 2'd2;
            end
            OP_JALR:   o_wb_sel = 2'd2;
            OP_BRANCH: begin
                o_a_sel   = 1'b1;
                o_imm_sel = 3'd2;
                o_br_un   = w_f3[2] & w_f3[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_f3)
            3'd0:    w_taken = i_beq;
            3'd1:    w_taken = ~i_beq;
            3'd4:    w_taken = i_blt;
            3'd5:    w_taken = ~i_blt;
            3'd6:    w_taken = i_blt;
            3'd7:    w_taken = ~i_blt;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        o_instr_ready = 1'b0;
        o_pc_we       = 1'b0;
        o_pc_sel      = 1'b0;
        o_reg_we      = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_instr_ready = i_rst_n;
                if (i_instr_valid)
                    w_next = S_DECODE;
            end
            S_DECODE: w_next = w_dec_ok ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_is_branch) begin
                    if (w_f3[2:1] == 2'b01) begin
                        w_next = S_TRAP;
                    end else begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = w_taken;
                        w_next   = S_FETCH;
                    end
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = w_is_store;
                if (i_mem_ready) begin
                    o_pc_we = w_is_store;
                    w_next  = w_is_store ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                o_reg_we = (w_rd != 5'd0);
                o_pc_we  = 1'b1;
                o_pc_sel = w_is_jump;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && i_instr_valid)
                r_ir <= i_instr;
            r_cnt     <= ((r_state == S_MEM) && (w_next == S_MEM)) ? r_cnt + 1'b1 : '0;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a per-instruction model expands each instruction
// into an expected per-cycle trace that is compared against the DUT cycle by cycle.
module tb_multicycle_control_unit;

    localparam int MEM_TIMEOUT = 16;
    localparam int EW = 9;
    localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37,
                                        7'h17, 7'h6F, 7'h67, 7'h63};
    // ALU codes for funct3 0..7 without the alternate bit: ADD SLL SLT SLTU XOR SRL OR AND
    localparam int OP_TBL [8] = '{4, 7, 9, 10, 3, 6, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic        beq = 1'b0;
    logic        blt = 1'b0;
    logic        instr_ready, pc_we, pc_sel, reg_we, a_sel, b_sel, br_un;
    logic        mem_req, mem_we, illegal;
    logic [2:0]  imm_sel, mem_size, dbg_state;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [31:0] dbg_ir;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_valid(instr_valid),
        .o_instr_ready(instr_ready), .i_mem_ready(mem_ready), .i_beq(beq), .i_blt(blt),
        .o_pc_we(pc_we), .o_pc_sel(pc_sel), .o_reg_we(reg_we), .o_imm_sel(imm_sel),
        .o_a_sel(a_sel), .o_b_sel(b_sel), .o_br_un(br_un), .o_alu_op(alu_op),
        .o_wb_sel(wb_sel), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_size(mem_size),
        .o_illegal(illegal), .o_dbg_state(dbg_state), .o_dbg_ir(dbg_ir)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic        mem_ready;
        logic        beq;
        logic        blt;
    } stim_t;

    stim_t          stim_q[$];
    logic [EW-1:0]  exp_q[$];

    // Expected datapath setup of the instruction currently in flight.
    logic [31:0] x_ir;
    logic [3:0]  x_alu;
    logic [2:0]  x_imm;
    logic        x_imm_care, x_a, x_b, x_brun;
    logic [1:0]  x_wb;
    logic [2:0]  x_size;

    int dir_beq = -1;
    int dir_blt = -1;
    int idle_max = 2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Entry: [8:7] phase (0 none, 1 exec, 2 mem, 3 wb), then ready pc_we pc_sel reg_we mem_req mem_we illegal
    function automatic logic [EW-1:0] mk(input logic [1:0] ph, input logic rdy, input logic pcwe,
                                         input logic pcsel, input logic regwe, input logic mreq,
                                         input logic mwe, input logic ill);
        return {ph, rdy, pcwe, pcsel, regwe, mreq, mwe, ill};
    endfunction

    function automatic stim_t rnd_stim(input logic v);
        stim_t s;
        s.valid     = v;
        s.instr     = $urandom;
        s.mem_ready = 1'($urandom);
        s.beq       = (dir_beq < 0) ? 1'($urandom) : dir_beq[0];
        s.blt       = (dir_blt < 0) ? 1'($urandom) : dir_blt[0];
        return s;
    endfunction

    // 0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR, 8 BRANCH, -1 illegal at decode
    function automatic int classify(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        for (int k = 0; k < 9; k++) begin
            if (ins[6:0] == OPCS[k]) begin
                if (k == 0 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
                    return -1;
                if (k == 1 && f3 == 3'd1 && f7 != 7'h00)
                    return -1;
                if (k == 1 && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
                    return -1;
                return k;
            end
        end
        return -1;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic b_eq, input logic b_lt);
        case (f3)
            3'd0: return b_eq;
            3'd1: return !b_eq;
            3'd4: return b_lt;
            3'd5: return !b_lt;
            3'd6: return b_lt;
            default: return !b_lt;
        endcase
    endfunction

    task automatic push_trap_tail();
        repeat (4) begin
            stim_q.push_back(rnd_stim(1'b1));
            exp_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 1));
        end
    endtask

    // Expand one instruction into stimulus and expected trace.
    task automatic build_instr(input logic [31:0] ins, input int wait_n, output bit trapped);
        int    cls;
        stim_t s;
        logic  tk, rdy;
        logic [2:0] f3;
        f3 = ins[14:12];
        trapped = 0;
        cls = classify(ins);
        repeat ($urandom_range(0, idle_max)) begin
            stim_q.push_back(rnd_stim(1'b0));
            exp_q.push_back(mk(2'd0, 1, 0, 0, 0, 0, 0, 0));
        end
        s = rnd_stim(1'b1);
        s.instr = ins;
        stim_q.push_back(s);
        exp_q.push_back(mk(2'd0, 1, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(rnd_stim(1'($urandom)));
        exp_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
        if (cls < 0) begin
            push_trap_tail();
            trapped = 1;
            return;
        end
        x_ir       = ins;
        x_size     = f3;
        x_a        = (cls == 5 || cls == 6 || cls == 8);
        x_b        = (cls != 0);
        x_brun     = (cls == 8) && (f3 == 3'd6 || f3 == 3'd7);
        x_wb       = (cls == 2) ? 2'd0 : (cls == 6 || cls == 7) ? 2'd2 : 2'd1;
        x_imm_care = (cls != 0);
        x_imm      = (cls == 3) ? 3'd1 : (cls == 8) ? 3'd2 : (cls == 4 || cls == 5) ? 3'd3 :
                     (cls == 6) ? 3'd4 : 3'd0;
        if (cls == 4)
            x_alu = 4'd11;
        else if (cls == 0 && ins[30] && f3 == 3'd0)
            x_alu = 4'd5;
        else if ((cls == 0 || cls == 1) && ins[30] && f3 == 3'd5)
            x_alu = 4'd8;
        else if (cls <= 1)
            x_alu = 4'(OP_TBL[f3]);
        else
            x_alu = 4'd4;

        s = rnd_stim(1'($urandom));
        stim_q.push_back(s);
        if (cls == 8) begin
            if (f3 == 3'd2 || f3 == 3'd3) begin
                exp_q.push_back(mk(2'd1, 0, 0, 0, 0, 0, 0, 0));
                push_trap_tail();
                trapped = 1;
            end else begin
                tk = branch_taken(f3, s.beq, s.blt);
                exp_q.push_back(mk(2'd1, 0, 1, tk, 0, 0, 0, 0));
            end
            return;
        end
        exp_q.push_back(mk(2'd1, 0, 0, 0, 0, 0, 0, 0));
        if (cls == 2 || cls == 3) begin
            rdy = 0;
            for (int k = 1; k <= MEM_TIMEOUT; k++) begin
                rdy = (k == wait_n);
                s = rnd_stim(1'($urandom));
                s.mem_ready = rdy;
                stim_q.push_back(s);
                exp_q.push_back(mk(2'd2, 0, (cls == 3) && rdy, 0, 0, 1, cls == 3, 0));
                if (rdy) break;
            end
            if (!rdy) begin
                push_trap_tail();
                trapped = 1;
                return;
            end
            if (cls == 3) return;
        end
        stim_q.push_back(rnd_stim(1'($urandom)));
        exp_q.push_back(mk(2'd3, 0, 1, cls == 6 || cls == 7, ins[11:7] != 5'd0, 0, 0, 0));
    endtask

    task automatic run_seq();
        stim_t s;
        logic [EW-1:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            instr_valid = s.valid;
            instr       = s.instr;
            mem_ready   = s.mem_ready;
            beq         = s.beq;
            blt         = s.blt;
            #1;
            e = exp_q.pop_front();
            check_eq("instr_ready", instr_ready, e[6]);
            check_eq("pc_we", pc_we, e[5]);
            if (e[5]) check_eq("pc_sel", pc_sel, e[4]);
            check_eq("reg_we", reg_we, e[3]);
            check_eq("mem_req", mem_req, e[2]);
            check_eq("mem_we", mem_we, e[1]);
            check_eq("illegal", illegal, e[0]);
            if (e[8:7] != 2'd0) begin
                check_eq("ir_held", dbg_ir, x_ir);
                check_eq("alu_op", alu_op, x_alu);
                check_eq("a_sel", a_sel, x_a);
                check_eq("b_sel", b_sel, x_b);
                check_eq("br_un", br_un, x_brun);
                if (x_imm_care) check_eq("imm_sel", imm_sel, x_imm);
                if (e[8:7] == 2'd2) check_eq("mem_size", mem_size, x_size);
                if (e[8:7] == 2'd3) check_eq("wb_sel", wb_sel, x_wb);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ready", instr_ready, 0);
        check_eq("rst_strobes", {pc_we, reg_we, mem_req, mem_we}, 0);
        check_eq("rst_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", instr_ready, 1);
        check_eq("post_rst_illegal", illegal, 0);
    endtask

    task automatic run_one(input logic [31:0] ins, input int wait_n);
        bit tr;
        build_instr(ins, wait_n, tr);
        run_seq();
        if (tr) do_reset();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        int          k, sel;
        bit          known;
        ins = $urandom;
        k = $urandom_range(0, 9);
        if (k == 9) begin
            do begin
                op = 7'($urandom);
                known = 0;
                for (int j = 0; j < 9; j++) if (op == OPCS[j]) known = 1;
            end while (known);
        end else begin
            op = OPCS[k];
        end
        ins[6:0] = op;
        if (k <= 1) begin
            sel = $urandom_range(0, 9);
            ins[31:25] = (sel < 6) ? 7'h00 : (sel < 9) ? 7'h20 : 7'($urandom);
        end
        return ins;
    endfunction

    initial begin
        int wn;
        do_reset();
        // add x3,x1,x2 with valid already high
        idle_max = 0;
        run_one(32'h002081B3, 0);
        // beq x0,x0,8 taken; bge with blt=0 taken
        dir_beq = 1;
        run_one(32'h00000463, 0);
        dir_beq = -1;
        dir_blt = 0;
        run_one(32'h0000D463, 0);
        dir_blt = -1;
        // lw with ready in third MEM cycle, then sw
        run_one(32'h0000A283, 3);
        run_one(32'h0050A023, 2);
        // all-zero word traps; reset clears it
        run_one(32'h00000000, 0);
        // load that never sees mem_ready
        run_one(32'h0000A283, 0);
        // addi x0,x0,1: no register write but PC advances
        run_one(32'h00100013, 0);
        // reset in the middle of MEM
        begin
            bit tr;
            build_instr(32'h0000A283, 0, tr);
            while (exp_q.size() > 5) begin
                void'(exp_q.pop_back());
                void'(stim_q.pop_back());
            end
            run_seq();
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check_eq("mid_mem_req", mem_req, 1);
            rst_n = 1'b0;
            #1;
            check_eq("async_rst_mem_req", mem_req, 0);
            check_eq("async_rst_strobes", {instr_ready, pc_we, reg_we, mem_we}, 0);
            @(negedge clk);
            instr_valid = 1'b0;
            rst_n = 1'b1;
            #1;
            check_eq("rst_release_ready", instr_ready, 1);
        end
        idle_max = 2;
        for (int n = 0; n < 150; n++) begin
            wn = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, 4);
            run_one(gen_instr(), wn);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
